// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and constants for the RX frame controller: FSM state encoding,
// the per-frame status word and its width, and a saturating-increment helper.
package rx_frame_ctrl_pkg;

  localparam int LEN_W           = 16;
  localparam int STW_W           = LEN_W + 2;
  localparam int SPACE_W_DEF     = 12;
  localparam int MAX_FRM_WDS_DEF = 1200;
  localparam int STQ_DEPTH_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 2048;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ARMED  = 2'd1,
    BUSY   = 2'd2,
    COMMIT = 2'd3
  } rx_state_e;

  // One entry per finished frame, as seen by the host.
  typedef struct packed {
    logic             timeout;
    logic             good;
    logic [LEN_W-1:0] len;
  } status_word_t;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rx_status_fifo.sv
// First-word-fall-through status queue. The head entry is presented
// combinationally from storage; push and pop in the same cycle are both honoured.
// Push into a full queue and pop from an empty one are dropped.
module rx_status_fifo
  import rx_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = STQ_DEPTH_DEF
) (
  input  logic         rxclk,
  input  logic         reset,
  input  logic         push,
  input  status_word_t push_data,
  input  logic         pop,
  output status_word_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  status_word_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately left unreset; only pointers and count need it,
  // and an entry is never presented as valid before it has been written.
  always_ff @(posedge rxclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// RX frame controller: gates the RX engine's recv_enable so a frame is only
// accepted when the data buffer and status queue can take a whole frame,
// records each frame's verdict and length in a status queue, and aborts frames
// that stall past the watchdog limit.
// Build option: define RX_FRAME_STATS_EN to add saturating good/bad/abort
// counters with a synchronous stats_clr.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int SPACE_W     = SPACE_W_DEF,
  parameter int MAX_FRM_WDS = MAX_FRM_WDS_DEF,
  parameter int STQ_DEPTH   = STQ_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic               cfg_rx_en,
  input  logic               get_sfd,
  input  logic               good_frame_get,
  input  logic               bad_frame_get,
  input  logic [LEN_W-1:0]   rx_frame_len,
  input  logic [SPACE_W-1:0] data_fifo_space,
  output logic               recv_enable,
  output logic               rx_abort,
  output logic               st_valid,
  input  logic               st_ready,
  output logic               st_good,
  output logic               st_timeout,
  output logic [LEN_W-1:0]   st_len,
  output logic               busy
`ifdef RX_FRAME_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        good_cnt,
  output logic [31:0]        bad_cnt,
  output logic [31:0]        abort_cnt
`endif
);

  localparam int         WD_W   = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  rx_state_e        state_q, state_d;
  logic             recv_enable_q, recv_enable_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  status_word_t     cap_q, cap_d;
  status_word_t     stq_head;
  logic             stq_push, stq_full, stq_empty;
  logic             arm_ok, verdict, commit_entry;

  assign arm_ok  = cfg_rx_en & (data_fifo_space >= SPACE_W'(MAX_FRM_WDS)) & ~stq_full;
  assign verdict = good_frame_get | bad_frame_get;

  // Next-state, enable, watchdog and verdict capture.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    recv_enable_d = 1'b0;
    wdog_d        = wdog_q;
    cap_d         = cap_q;
    rx_abort      = 1'b0;
    stq_push      = 1'b0;
    case (state_q)
      OFF: begin
        if (cfg_rx_en) state_d = ARMED;
      end
      ARMED: begin
        if (get_sfd && recv_enable_q) begin
          state_d       = BUSY;
          recv_enable_d = 1'b1;
          wdog_d        = '0;
        end else if (!cfg_rx_en) begin
          state_d = OFF;
        end else begin
          recv_enable_d = arm_ok;
        end
      end
      BUSY: begin
        wdog_d = wdog_q + WD_W'(1);
        if (verdict) begin
          // Simultaneous good and bad pulses resolve to bad.
          state_d = COMMIT;
          cap_d   = '{timeout: 1'b0, good: good_frame_get & ~bad_frame_get, len: rx_frame_len};
        end else if (wdog_q == WD_MAX) begin
          state_d  = COMMIT;
          rx_abort = 1'b1;
          cap_d    = '{timeout: 1'b1, good: 1'b0, len: rx_frame_len};
        end else begin
          recv_enable_d = 1'b1;
        end
      end
      COMMIT: begin
        stq_push = 1'b1;
        state_d  = cfg_rx_en ? ARMED : OFF;
      end
      default: state_d = OFF;
    endcase
  end

  assign commit_entry = (state_q == BUSY) && (state_d == COMMIT);

  // Controller registers.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q       <= OFF;
      recv_enable_q <= 1'b0;
      wdog_q        <= '0;
      cap_q         <= '0;
    end else begin
      state_q       <= state_d;
      recv_enable_q <= recv_enable_d;
      wdog_q        <= wdog_d;
      cap_q         <= cap_d;
    end
  end

  rx_status_fifo #(
    .DEPTH (STQ_DEPTH)
  ) u_stq (
    .rxclk     (rxclk),
    .reset     (reset),
    .push      (stq_push),
    .push_data (cap_q),
    .pop       (st_ready),
    .head      (stq_head),
    .full      (stq_full),
    .empty     (stq_empty)
  );

  assign recv_enable = recv_enable_q;
  assign busy        = (state_q == BUSY) || (state_q == COMMIT);
  assign st_valid    = ~stq_empty;
  assign st_timeout  = stq_head.timeout;
  assign st_good     = stq_head.good;
  assign st_len      = stq_head.len;

`ifdef RX_FRAME_STATS_EN
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] bad_cnt_q, bad_cnt_d;
  logic [31:0] abort_cnt_q, abort_cnt_d;

  // Classify each frame as it enters COMMIT; a clear beats any increment.
  always_comb begin
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (stats_clr) begin
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      abort_cnt_d = '0;
    end else if (commit_entry) begin
      if (rx_abort)        abort_cnt_d = sat_inc(abort_cnt_q);
      else if (cap_d.good) good_cnt_d  = sat_inc(good_cnt_q);
      else                 bad_cnt_d   = sat_inc(bad_cnt_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign good_cnt  = good_cnt_q;
  assign bad_cnt   = bad_cnt_q;
  assign abort_cnt = abort_cnt_q;
`else
  logic unused_commit_entry;
  assign unused_commit_entry = commit_entry;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed testbench for rx_frame_ctrl. Inputs change and outputs are sampled
// on the falling edge of rxclk; the design acts on the rising edge.
module tb_rx_frame_ctrl;
  import rx_frame_ctrl_pkg::*;

  logic             rxclk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_rx_en = 1'b0;
  logic             get_sfd = 1'b0;
  logic             good_frame_get = 1'b0;
  logic             bad_frame_get = 1'b0;
  logic [LEN_W-1:0] rx_frame_len = '0;
  logic [11:0]      data_fifo_space = '0;
  logic             st_ready = 1'b0;
  logic             recv_enable, rx_abort, st_valid, st_good, st_timeout, busy;
  logic [LEN_W-1:0] st_len;
`ifdef RX_FRAME_STATS_EN
  logic             stats_clr = 1'b0;
  logic [31:0]      good_cnt, bad_cnt, abort_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 rxclk = ~rxclk;

  rx_frame_ctrl dut (
    .rxclk           (rxclk),
    .reset           (reset),
    .cfg_rx_en       (cfg_rx_en),
    .get_sfd         (get_sfd),
    .good_frame_get  (good_frame_get),
    .bad_frame_get   (bad_frame_get),
    .rx_frame_len    (rx_frame_len),
    .data_fifo_space (data_fifo_space),
    .recv_enable     (recv_enable),
    .rx_abort        (rx_abort),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_good         (st_good),
    .st_timeout      (st_timeout),
    .st_len          (st_len),
    .busy            (busy)
`ifdef RX_FRAME_STATS_EN
    ,
    .stats_clr       (stats_clr),
    .good_cnt        (good_cnt),
    .bad_cnt         (bad_cnt),
    .abort_cnt       (abort_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rxclk);
  endtask

  // Bounded wait for the controller to arm; an expired bound is a failure.
  task automatic wait_arm();
    for (int i = 0; i < 20 && !recv_enable; i++) cyc(1);
    if (!recv_enable) check("arm_wait", recv_enable, 1);
  endtask

  // Full frame: SFD, one verdict cycle, then the COMMIT cycle.
  task automatic run_frame(input logic g, input logic b, input logic [LEN_W-1:0] len);
    wait_arm();
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    good_frame_get = g; bad_frame_get = b; rx_frame_len = len;
    cyc(1);
    good_frame_get = 1'b0; bad_frame_get = 1'b0;
    cyc(1);
  endtask

  task automatic pop1();
    st_ready = 1'b1; cyc(1); st_ready = 1'b0;
  endtask

  initial begin
    int aborts;
    int abort_at;

    // Reset state
    cyc(2);
    check("rst_recv_enable", recv_enable, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_abort", rx_abort, 0);
    reset = 1'b0;

    // Space gate
    cfg_rx_en = 1'b1; data_fifo_space = 12'd1199;
    cyc(3);
    check("gate_1199", recv_enable, 0);
    data_fifo_space = 12'd1200;
    cyc(1);
    check("gate_1200", recv_enable, 1);
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    check("sfd_busy", busy, 1);
    good_frame_get = 1'b1; rx_frame_len = 16'd64; cyc(1); good_frame_get = 1'b0;
    check("commit_recv_off", recv_enable, 0);
    cyc(1);
    check("f1_valid", st_valid, 1);
    check("f1_good", st_good, 1);
    check("f1_timeout", st_timeout, 0);
    check("f1_len", st_len, 64);
    pop1();
    check("f1_popped", st_valid, 0);

    // Queue full: eight frames, no host pops
    for (int i = 0; i < 8; i++) run_frame(1'b1, 1'b0, LEN_W'(100 + i));
    cyc(2);
    check("qfull_recv_off", recv_enable, 0);
    check("qfull_head", st_len, 100);
    pop1();
    cyc(1);
    check("qfull_rearm", recv_enable, 1);
    for (int i = 1; i < 8; i++) begin
      check("q_order", st_len, 32'(100 + i));
      pop1();
    end
    check("q_drained", st_valid, 0);

    // Watchdog expiry
    wait_arm();
    rx_frame_len = 16'd777;
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    aborts = 0; abort_at = -1;
    for (int i = 0; i < 2060; i++) begin
      if (rx_abort) begin
        aborts++;
        if (abort_at < 0) abort_at = i;
      end
      cyc(1);
    end
    check("wd_abort_pulses", aborts, 1);
    check("wd_abort_cycle", abort_at, 2047);
    check("wd_valid", st_valid, 1);
    check("wd_timeout", st_timeout, 1);
    check("wd_good", st_good, 0);
    check("wd_len", st_len, 777);
    pop1();

    // Verdict on the expiry cycle wins
    wait_arm();
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    cyc(2046);
    check("pre_expiry_abort", rx_abort, 0);
    cyc(1);
    good_frame_get = 1'b1; rx_frame_len = 16'd55;
    #2;
    check("expiry_verdict_abort", rx_abort, 0);
    @(negedge rxclk);
    good_frame_get = 1'b0;
    cyc(1);
    check("ev_timeout", st_timeout, 0);
    check("ev_good", st_good, 1);
    check("ev_len", st_len, 55);
    pop1();

    // Good and bad together count as bad
    run_frame(1'b1, 1'b1, 16'd200);
    check("both_good", st_good, 0);
    check("both_timeout", st_timeout, 0);
    check("both_len", st_len, 200);
    pop1();

    // cfg_rx_en dropped mid-frame
    wait_arm();
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    cfg_rx_en = 1'b0;
    cyc(3);
    check("cfgdrop_busy", busy, 1);
    check("cfgdrop_recv_held", recv_enable, 1);
    good_frame_get = 1'b1; rx_frame_len = 16'd300; cyc(1); good_frame_get = 1'b0;
    cyc(1);
    check("cfgdrop_committed", st_valid, 1);
    check("cfgdrop_len", st_len, 300);
    get_sfd = 1'b1; cyc(2); get_sfd = 1'b0;
    check("off_sfd_ignored", busy, 0);
    check("off_recv", recv_enable, 0);
    pop1();
    cfg_rx_en = 1'b1;

    // Async reset during a frame
    run_frame(1'b1, 1'b0, 16'd12);
    wait_arm();
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    check("ar_pre_busy", busy, 1);
    check("ar_pre_valid", st_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_recv", recv_enable, 0);
    check("ar_valid", st_valid, 0);
    check("ar_busy", busy, 0);
    @(negedge rxclk);
    reset = 1'b0;
    cyc(2);
    check("ar_queue_empty", st_valid, 0);

`ifdef RX_FRAME_STATS_EN
    // Statistics: 3 good, 2 bad, 1 abort
    check("stats_after_reset", good_cnt, 0);
    for (int i = 0; i < 3; i++) begin run_frame(1'b1, 1'b0, 16'd60); pop1(); end
    run_frame(1'b0, 1'b1, 16'd61); pop1();
    run_frame(1'b1, 1'b1, 16'd62); pop1();
    wait_arm();
    get_sfd = 1'b1; cyc(1); get_sfd = 1'b0;
    cyc(2050);
    pop1();
    check("stats_good", good_cnt, 3);
    check("stats_bad", bad_cnt, 2);
    check("stats_abort", abort_cnt, 1);
    stats_clr = 1'b1; cyc(1); stats_clr = 1'b0;
    check("clr_good", good_cnt, 0);
    check("clr_bad", bad_cnt, 0);
    check("clr_abort", abort_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
